cond_stage: RTL and testbench
=============================

COND_STAGE -- requirements
Module: cond_stage

Interface
REQ-001 The block SHALL have parameter n, default 32, setting the data-path width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port CondE, input, 4 bits: ARM condition field of the Execute instruction.
REQ-005 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the Execute-stage ALU.
REQ-006 The block SHALL have port FlagWriteE, input, 2 bits: [1] enables the N,Z update; [0] enables the C,V update.
REQ-007 The block SHALL have ports RegWriteE, MemWriteE, MemtoRegE and BranchE, each input, 1 bit: Execute control bits.
REQ-008 The block SHALL have ports ALUResultE (input, n bits), WriteDataE (input, n bits) and WA3E (input, 4 bits): Execute data and destination register.
REQ-009 The block SHALL have ports StallM and FlushM, each input, 1 bit: hold the M register, or load a bubble into it.
REQ-010 The block SHALL have port Flags, output, 4 bits: current architectural {N,Z,C,V}.
REQ-011 The block SHALL have ports CondExE and BranchTakenE, each output, 1 bit, combinational: condition passed; branch taken.
REQ-012 The block SHALL have ports RegWriteM, MemWriteM and MemtoRegM (output, 1 bit each), ALUOutM and WriteDataM (output, n bits each), and WA3M (output, 4 bits).

Function
REQ-013 CondExE SHALL be evaluated from the registered Flags, never from ALUFlags, per ARM encoding:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1
REQ-014 BranchTakenE SHALL equal BranchE & CondExE, with zero-cycle latency.
REQ-015 On a rising edge with no stall and no flush, Flags[3:2] SHALL load ALUFlags[3:2] iff FlagWriteE[1]&CondExE.
REQ-016 Under the same conditions, Flags[1:0] SHALL load ALUFlags[1:0] iff FlagWriteE[0]&CondExE; the unwritten half is held.
REQ-017 A flag update SHALL be visible to CondExE exactly one cycle later, so back-to-back dependent instructions need no interlock.
REQ-018 On an unstalled, unflushed edge, the M register SHALL capture RegWriteE&CondExE, MemWriteE&CondExE, MemtoRegE, ALUResultE, WriteDataE and WA3E (latency 1).
REQ-019 With StallM=1, the M register and Flags SHALL both hold; no flag write occurs, because the Execute instruction will be re-presented.
REQ-020 With FlushM=1, the M register SHALL load all zeros and Flags SHALL hold; FlushM takes priority over StallM.
REQ-021 A failed condition SHALL pass data fields to M unchanged while forcing RegWriteM=MemWriteM=0.

Reset
REQ-022 While reset=0, Flags, all M-register controls, ALUOutM, WriteDataM and WA3M SHALL be 0 immediately, independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard any pending flag write; the first edge after release behaves per REQ-015..REQ-020.

Structure
REQ-024 Package cond_pkg SHALL hold the 4-bit condition enum (EQ..AL, NV) and the flag bit-index constants N=3, Z=2, C=1, V=0.
REQ-025 The combinational evaluator SHALL be the sub-module cond_check (CondE and Flags in, CondExE out); flag and M registers stay in cond_stage.

Verification
REQ-026 Reset, then CondE=1110 with RegWriteE=1, ALUResultE=32'h5 -> next edge RegWriteM=1, ALUOutM=32'h5, Flags=0000.
REQ-027 SUBS with ALUFlags=0100 and FlagWriteE=11, then BEQ (CondE=0000, BranchE=1) the next cycle -> BranchTakenE=1.
REQ-028 Flags=0000, CondE=0000, RegWriteE=1, MemWriteE=1, FlagWriteE=11, ALUFlags=1111 -> RegWriteM=0, MemWriteM=0, Flags stay 0000.
REQ-029 FlagWriteE=10, ALUFlags=1001, prior Flags=0011 -> Flags=1011, showing split N,Z/C,V update.
REQ-030 StallM=1 with FlagWriteE=11 -> M outputs and Flags unchanged; StallM=FlushM=1 -> M controls 0, Flags unchanged.
REQ-031 Assert reset between edges with a pending flag write -> Flags=0000 and M outputs 0 at once, with no clock edge.

Source files
------------

// File: rtl/cond_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_pkg : ARM condition-code encodings and flag bit positions       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_check : combinational ARM condition evaluator                   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] Flags,
  output logic       CondExE
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = Flags[N];
  assign w_z  = Flags[Z];
  assign w_c  = Flags[C];
  assign w_v  = Flags[V];
  assign w_ge = (w_n == w_v);

  always_comb begin
    CondExE = 1'b1;
    case (cond_e'(CondE))
      EQ: CondExE = w_z;
      NE: CondExE = ~w_z;
      CS: CondExE = w_c;
      CC: CondExE = ~w_c;
      MI: CondExE = w_n;
      PL: CondExE = ~w_n;
      VS: CondExE = w_v;
      VC: CondExE = ~w_v;
      HI: CondExE = w_c & ~w_z;
      LS: CondExE = ~w_c | w_z;
      GE: CondExE = w_ge;
      LT: CondExE = ~w_ge;
      GT: CondExE = ~w_z & w_ge;
      LE: CondExE = w_z | ~w_ge;
      AL: CondExE = 1'b1;
      NV: CondExE = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_stage : Execute-stage condition unit, flag register, E->M reg   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module cond_stage
  import cond_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   CondE,
  input  logic [3:0]   ALUFlags,
  input  logic [1:0]   FlagWriteE,
  input  logic         RegWriteE,
  input  logic         MemWriteE,
  input  logic         MemtoRegE,
  input  logic         BranchE,
  input  logic [n-1:0] ALUResultE,
  input  logic [n-1:0] WriteDataE,
  input  logic [3:0]   WA3E,
  input  logic         StallM,
  input  logic         FlushM,
  output logic [3:0]   Flags,
  output logic         CondExE,
  output logic         BranchTakenE,
  output logic         RegWriteM,
  output logic         MemWriteM,
  output logic         MemtoRegM,
  output logic [n-1:0] ALUOutM,
  output logic [n-1:0] WriteDataM,
  output logic [3:0]   WA3M
);

  logic [3:0] r_flags;
  logic       w_advance;

  // Condition is judged against architectural flags only, so a flag write
  // lands exactly in time for the following instruction.
  cond_check u_cond_check (
    .CondE   (CondE),
    .Flags   (r_flags),
    .CondExE (CondExE)
  );

  assign Flags        = r_flags;
  assign BranchTakenE = BranchE & CondExE;
  assign w_advance    = ~StallM & ~FlushM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_advance) begin
      if (FlagWriteE[1] && CondExE) begin
        r_flags[N] <= ALUFlags[N];
        r_flags[Z] <= ALUFlags[Z];
      end
      if (FlagWriteE[0] && CondExE) begin
        r_flags[C] <= ALUFlags[C];
        r_flags[V] <= ALUFlags[V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= 4'd0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= 4'd0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE & CondExE;
      MemWriteM  <= MemWriteE & CondExE;
      MemtoRegM  <= MemtoRegE;
      ALUOutM    <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cond_stage : directed self-checking bench for cond_stage          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_cond_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  CondE;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagWriteE;
  logic        RegWriteE, MemWriteE, MemtoRegE, BranchE;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  WA3E;
  logic        StallM, FlushM;
  logic [3:0]  Flags;
  logic        CondExE, BranchTakenE;
  logic        RegWriteM, MemWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [3:0]  WA3M;

  int checks = 0;
  int errors = 0;

  cond_stage #(.n(32)) dut (
    .clk(clk), .reset(reset), .CondE(CondE), .ALUFlags(ALUFlags),
    .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .MemtoRegE(MemtoRegE), .BranchE(BranchE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .WA3E(WA3E), .StallM(StallM), .FlushM(FlushM),
    .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CondE = 4'b1110; ALUFlags = 4'b0000; FlagWriteE = 2'b00;
    RegWriteE = 1'b0; MemWriteE = 1'b0; MemtoRegE = 1'b0; BranchE = 1'b0;
    ALUResultE = 32'h0; WriteDataE = 32'h0; WA3E = 4'h0;
    StallM = 1'b0; FlushM = 1'b0;
  endtask

  // Load the flag register with an unconditional full flag write.
  task automatic set_flags(input logic [3:0] f);
    idle();
    FlagWriteE = 2'b11; ALUFlags = f;
    step();
    chk("set_flags", {28'h0, Flags}, {28'h0, f});
    idle();
  endtask

  task automatic cond_table(input logic [15:0] mask, input string tag);
    for (int i = 0; i < 16; i++) begin
      CondE = 4'(i); BranchE = 1'b1;
      #1;
      chk({tag, "_cond"}, {31'h0, CondExE}, {31'h0, mask[i]});
      chk({tag, "_br"}, {31'h0, BranchTakenE}, {31'h0, mask[i]});
    end
    idle();
  endtask

  task automatic m_all(input string tag, input logic rw, input logic mw, input logic mr,
                       input logic [31:0] ao, input logic [31:0] wd, input logic [3:0] wa);
    chk({tag, "_RegWriteM"}, {31'h0, RegWriteM}, {31'h0, rw});
    chk({tag, "_MemWriteM"}, {31'h0, MemWriteM}, {31'h0, mw});
    chk({tag, "_MemtoRegM"}, {31'h0, MemtoRegM}, {31'h0, mr});
    chk({tag, "_ALUOutM"}, ALUOutM, ao);
    chk({tag, "_WriteDataM"}, WriteDataM, wd);
    chk({tag, "_WA3M"}, {28'h0, WA3M}, {28'h0, wa});
  endtask

  initial begin
    reset = 1'b0;
    idle();
    RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1; ALUResultE = 32'hDEAD;
    WriteDataE = 32'hBEEF; WA3E = 4'hF; FlagWriteE = 2'b11; ALUFlags = 4'hF;
    #2;
    chk("rst_flags", {28'h0, Flags}, 32'h0);
    m_all("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    chk("rst_edge_flags", {28'h0, Flags}, 32'h0);
    m_all("rst_edge", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b1;
    idle();

    // AL instruction writes through to M
    RegWriteE = 1'b1; ALUResultE = 32'h5; WriteDataE = 32'hA; WA3E = 4'h3;
    #1;
    chk("al_condex", {31'h0, CondExE}, 32'h1);
    step();
    m_all("al", 1'b1, 1'b0, 1'b0, 32'h5, 32'hA, 4'h3);
    chk("al_flags", {28'h0, Flags}, 32'h0);
    idle();

    // SUBS sets Z, BEQ right behind it is taken
    FlagWriteE = 2'b11; ALUFlags = 4'b0100; RegWriteE = 1'b1;
    step();
    chk("subs_flags", {28'h0, Flags}, 32'h4);
    idle();
    CondE = 4'b0000; BranchE = 1'b1;
    #1;
    chk("beq_taken", {31'h0, BranchTakenE}, 32'h1);
    CondE = 4'b0001;
    #1;
    chk("bne_not_taken", {31'h0, BranchTakenE}, 32'h0);
    BranchE = 1'b0; CondE = 4'b0000;
    #1;
    chk("beq_nobranch", {31'h0, BranchTakenE}, 32'h0);
    idle();

    // Failed condition: writes suppressed, data passes, no flag update
    set_flags(4'b0000);
    CondE = 4'b0000; RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1;
    FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    ALUResultE = 32'h77; WriteDataE = 32'h88; WA3E = 4'h6;
    #1;
    chk("fail_condex", {31'h0, CondExE}, 32'h0);
    step();
    m_all("fail", 1'b0, 1'b0, 1'b1, 32'h77, 32'h88, 4'h6);
    chk("fail_flags", {28'h0, Flags}, 32'h0);
    idle();

    // Split flag update
    set_flags(4'b0011);
    FlagWriteE = 2'b10; ALUFlags = 4'b1001;
    step();
    chk("split_nz", {28'h0, Flags}, 32'hB);
    FlagWriteE = 2'b01; ALUFlags = 4'b0100;
    step();
    chk("split_cv", {28'h0, Flags}, 32'h8);
    idle();

    // Full condition table against three flag patterns (bit i = cond i)
    cond_table(16'hEA9A, "f1000");
    set_flags(4'b0110);
    cond_table(16'hE6A5, "f0110");
    set_flags(4'b0011);
    cond_table(16'hE966, "f0011");

    // Stall holds everything, flush zeroes M, flush beats stall
    RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1;
    ALUResultE = 32'h11; WriteDataE = 32'h22; WA3E = 4'h5;
    step();
    m_all("pre_stall", 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 4'h5);
    StallM = 1'b1; RegWriteE = 1'b0; ALUResultE = 32'h99; WA3E = 4'h9;
    FlagWriteE = 2'b11; ALUFlags = 4'b1100;
    step();
    m_all("stall", 1'b1, 1'b1, 1'b1, 32'h11, 32'h22, 4'h5);
    chk("stall_flags", {28'h0, Flags}, 32'h3);
    FlushM = 1'b1;
    step();
    m_all("flush_stall", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("flush_flags", {28'h0, Flags}, 32'h3);
    idle();

    // Asynchronous reset mid-cycle with a flag write pending
    RegWriteE = 1'b1; ALUResultE = 32'h33; WriteDataE = 32'h44; WA3E = 4'h7;
    step();
    FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    chk("async_flags", {28'h0, Flags}, 32'h0);
    m_all("async", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    reset = 1'b1;
    idle();
    FlagWriteE = 2'b11; ALUFlags = 4'b1010;
    step();
    chk("post_rst_flags", {28'h0, Flags}, 32'hA);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
